// File: rtl/booth_mul_arbiter.sv
// Round-robin front end for a single shared Booth multiplier: grants one requester at a time,
// runs the multiplier under a watchdog and returns the product to the originator with backpressure.
module booth_mul_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_a,
    input  logic [N*WIDTH-1:0]   req_b,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    input  logic [N-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_error,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    win;
    logic             found;
    logic [CW-1:0]    wdog;
    logic [WIDTH-1:0] a_arr [N];
    logic [WIDTH-1:0] b_arr [N];
    int               cand;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Search starts at ptr and wraps, so the most recent winner has lowest priority next time.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req_valid[PW'(cand)]) begin
                found = 1'b1;
                win   = PW'(cand);
            end
        end
    end

    // A grant pulse is suppressed while reset is held, since the request would be lost.
    assign req_ready = (state == IDLE && found && !rst) ? (ONE << win) : '0;
    assign rsp_valid = (state == RESP) ? (ONE << owner) : '0;
    assign mul_start = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wdog        <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_a <= a_arr[win];
                        mul_b <= b_arr[win];
                        owner <= win;
                        ptr   <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
                        wdog  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A done in the last watchdog cycle still wins over the timeout.
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_error   <= 1'b0;
                        state       <= RESP;
                    end else if (wdog == CW'(TIMEOUT)) begin
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    wdog  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one Booth multiplier (`Start_sig`/`Done_sig` handshake, `WIDTH`×`WIDTH` → `2*WIDTH` product) among `N` requesters. It accepts operand pairs through per-requester valid/ready ports and drives the multiplier's start/operand inputs. It routes each product back to its originator with backpressure, and aborts hung operations with a watchdog. It sits between the client blocks and the single multiplier instance.

## Interface
- `N`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width; product is `2*WIDTH`
- `TIMEOUT`, 64, max cycles `mul_start` may stay high without `mul_done` (≥ 2*WIDTH+4)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N  requester i has an operand pair
- `req_a`  in  N*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  N*WIDTH  operand B, same packing
- `req_ready`  out  N  one-hot pulse: pair accepted this cycle
- `rsp_valid`  out  N  one-hot: product for requester i is on `rsp_product`
- `rsp_ready`  in  N  requester i consumes response
- `rsp_product`  out  2*WIDTH  product (zero when `rsp_error`)
- `rsp_error`  out  1  qualifies `rsp_valid`: operation timed out
- `mul_start`  out  1  to multiplier `Start_sig`
- `mul_a`, `mul_b`  out  WIDTH  to multiplier `A`, `B`
- `mul_done`  in  1  from multiplier `Done_sig`
- `mul_product`  in  2*WIDTH  from multiplier `Product`

## Operation
- FSM states: IDLE, RUN, RESP, GAP.
- IDLE: if any `req_valid`, select winner by round-robin from pointer `ptr` (search ptr, ptr+1, … mod N). Pulse `req_ready[win]` this cycle. Latch `req_a/req_b` slice into `mul_a/mul_b`, latch `win` as `owner`, `ptr <= win+1 mod N`. Go to RUN. No request: stay.
- RUN: `mul_start`=1, `mul_a/mul_b` stable. Watchdog counter increments each RUN cycle.
  - `mul_done`=1: latch `mul_product`, `rsp_error`=0, go RESP.
  - Counter reaches `TIMEOUT` without done: product=0, `rsp_error`=1, go RESP.
- RESP: `mul_start`=0. `rsp_valid[owner]`=1, product/error held stable until `rsp_ready[owner]`=1; then go GAP. `rsp_ready` of non-owners ignored. New requests are not accepted in RESP (one operation in flight).
- GAP: one cycle, `mul_start`=0 (guarantees multiplier sees start low between operations), then IDLE.
- `mul_done` outside RUN is ignored. `req_valid` need not be held after `req_ready`; operands are sampled only in the grant cycle.
- Product is unsigned `WIDTH`×`WIDTH`, passed through unmodified; no truncation.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE, `ptr`=0, watchdog=0. All outputs 0: `req_ready`, `rsp_valid`, `rsp_product`, `rsp_error`, `mul_start`, `mul_a`, `mul_b`.
- Reset mid-operation: takes effect next edge. In-flight operation discarded, no response issued. Multiplier must be reset by the same `rst` at system level.
- Grant at edge k (IDLE, `req_ready` high in cycle k). `mul_start` rises at k+1.
- `mul_done` sampled at edge d: `mul_start` low and `rsp_valid` high from d+1.
- Minimum request-to-response latency: 2 + multiplier latency.
- Handshake completes at the edge where `rsp_valid` & `rsp_ready` are both 1. Earliest next grant is 2 cycles later (GAP, then IDLE grant).
- Timeout: `rsp_valid` with `rsp_error`=1 asserts exactly `TIMEOUT`+1 cycles after `mul_start` rose.
- `req_ready` never high outside IDLE; never more than one bit high.

## Test plan
- Single request: reset, requester 0 sends A=0x10, B=0x04 → `req_ready[0]` 1 cycle, `mul_start` held until `mul_done`, then `rsp_valid[0]` with `rsp_product`=0x0040, `rsp_error`=0.
- Fairness: all 4 requesters continuously valid (A=i+1, B=3) → grant order 0,1,2,3,0; products 3,6,9,12.
- Backpressure: hold `rsp_ready[2]`=0 for 10 cycles → `rsp_valid[2]` and product stable, no new `req_ready`, `mul_start`=0; release → GAP cycle then next grant.
- Timeout: multiplier model never asserts `mul_done` → after 65 cycles of `mul_start`, `rsp_valid[owner]`=1, `rsp_error`=1, product 0x0000.
- Reset mid-RUN: assert `rst` 3 cycles after grant → next cycle all outputs 0, no response; after release, requester 0 wins first.
- Edge values: A=B=0xFF → 0xFE01; A=0x00, B=0xFF → 0x0000; spurious `mul_done` pulse in IDLE ignored.
